// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: request/result bundle between the operand register file, the ALU core and writeback.
// Request side: in_valid, in_ready, a, b, alu_fun.
// Result side:  out_valid, out_ready, alu_out, alu_hi, carry/arith/logic/cmp/shift/zero/div0 flags.
// master: the requester/consumer (drives operands and out_ready); slave: the core.
interface alu_seq_core_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_fun;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] alu_hi;
   logic             carry_flag;
   logic             arith_flag;
   logic             logic_flag;
   logic             cmp_flag;
   logic             shift_flag;
   logic             zero_flag;
   logic             div0_flag;
   modport master (
      output in_valid, a, b, alu_fun, out_ready,
      input  in_ready, out_valid, alu_out, alu_hi,
      input  carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag, zero_flag, div0_flag
   );
   modport slave (
      input  in_valid, a, b, alu_fun, out_ready,
      output in_ready, out_valid, alu_out, alu_hi,
      output carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag, zero_flag, div0_flag
   );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked WIDTH-bit ALU with sequential shift-add multiply and restoring divide.
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - alu_seq_core_if.slave: operand request (valid/ready, a, b, alu_fun) and
//            registered result (valid/ready, alu_out, alu_hi, class/zero/div0 flags)
module alu_seq_core #(
   parameter int WIDTH = 16
) (
   input logic          clk_i,
   input logic          rst_ni,
   alu_seq_core_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef struct packed {
      logic carry;
      logic arith;
      logic lgc;
      logic cmp;
      logic shift;
      logic zero;
      logic div0;
   } flags_t;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       fun_q, fun_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] rhi_q, rhi_d;
   flags_t           flg_q, flg_d;
   logic [WIDTH:0]   sum_w, dif_w, madd_w, dsh_w, dsub_w;
   logic [SW-1:0]    sh_w;
   logic [SW:0]      rs_w;
   logic [WIDTH-1:0] sc_res, sc_hi, it_hi, it_lo;
   flags_t           sc_flg;
   logic             is_seq;
   // Single-cycle result, computed straight from the operands presented at accept.
   always_comb begin
      sh_w   = bus.b[SW-1:0];
      rs_w   = (SW+1)'(WIDTH) - {1'b0, sh_w};
      sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
      dif_w  = {1'b0, bus.a} - {1'b0, bus.b};
      is_seq = (bus.alu_fun == 4'h2) || (bus.alu_fun == 4'h3 && bus.b != '0);
      sc_res = '0;
      sc_hi  = '0;
      sc_flg = '0;
      case (bus.alu_fun)
         4'h0: begin sc_res = sum_w[WIDTH-1:0]; sc_flg.carry = sum_w[WIDTH]; sc_flg.arith = 1'b1; end
         4'h1: begin sc_res = dif_w[WIDTH-1:0]; sc_flg.carry = dif_w[WIDTH]; sc_flg.arith = 1'b1; end
         4'h2: sc_flg.arith = 1'b1;
         4'h3: begin sc_res = '1; sc_hi = bus.a; sc_flg.arith = 1'b1; sc_flg.div0 = 1'b1; end
         4'h4: begin sc_res = bus.a & bus.b; sc_flg.lgc = 1'b1; end
         4'h5: begin sc_res = bus.a | bus.b; sc_flg.lgc = 1'b1; end
         4'h6: begin sc_res = ~(bus.a & bus.b); sc_flg.lgc = 1'b1; end
         4'h7: begin sc_res = ~(bus.a | bus.b); sc_flg.lgc = 1'b1; end
         4'h8: begin sc_res = bus.a ^ bus.b; sc_flg.lgc = 1'b1; end
         4'h9: begin sc_res = ~(bus.a ^ bus.b); sc_flg.lgc = 1'b1; end
         4'hA: begin sc_res = (bus.a == bus.b) ? WIDTH'(1) : '0; sc_flg.cmp = 1'b1; end
         4'hB: begin sc_res = (bus.a > bus.b) ? WIDTH'(2) : '0; sc_flg.cmp = 1'b1; end
         4'hC: begin sc_res = (bus.a < bus.b) ? WIDTH'(3) : '0; sc_flg.cmp = 1'b1; end
         4'hD: begin sc_res = bus.a >> sh_w; sc_flg.shift = 1'b1; end
         4'hE: begin sc_res = bus.a << sh_w; sc_flg.shift = 1'b1; end
         // A zero amount makes rs_w == WIDTH, so the right-hand term vanishes.
         default: begin sc_res = (bus.a << sh_w) | (bus.a >> rs_w); sc_flg.shift = 1'b1; end
      endcase
      sc_flg.zero = (sc_res == '0);
   end
   // One multiply/divide iteration. Multiply: hi accumulates, lo holds the shifting multiplier
   // and collects product bits. Divide: hi is the partial remainder, lo shifts dividend bits out
   // and quotient bits in.
   always_comb begin
      madd_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      dsh_w  = {hi_q, lo_q[WIDTH-1]};
      dsub_w = dsh_w - {1'b0, b_q};
      it_hi  = (fun_q == 4'h2) ? madd_w[WIDTH:1]
             : (dsub_w[WIDTH] ? dsh_w[WIDTH-1:0] : dsub_w[WIDTH-1:0]);
      it_lo  = (fun_q == 4'h2) ? {madd_w[0], lo_q[WIDTH-1:1]}
             : {lo_q[WIDTH-2:0], ~dsub_w[WIDTH]};
   end
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      fun_d   = fun_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      rhi_d   = rhi_q;
      flg_d   = flg_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            b_d   = bus.b;
            fun_d = bus.alu_fun;
            hi_d  = '0;
            lo_d  = bus.a;
            cnt_d = '0;
            if (is_seq) state_d = BUSY;
            else begin
               state_d = DONE;
               res_d   = sc_res;
               rhi_d   = sc_hi;
               flg_d   = sc_flg;
            end
         end
         BUSY: begin
            hi_d  = it_hi;
            lo_d  = it_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SW'(WIDTH-1)) begin
               state_d     = DONE;
               res_d       = it_lo;
               rhi_d       = it_hi;
               flg_d       = '0;
               flg_d.arith = 1'b1;
               flg_d.carry = (fun_q == 4'h2) && (it_hi != '0);
               flg_d.zero  = (it_lo == '0);
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         b_q     <= '0;
         fun_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         rhi_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         fun_q   <= fun_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         rhi_q   <= rhi_d;
         flg_q   <= flg_d;
      end
   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.alu_out    = res_q;
   assign bus.alu_hi     = rhi_q;
   assign bus.carry_flag = flg_q.carry;
   assign bus.arith_flag = flg_q.arith;
   assign bus.logic_flag = flg_q.lgc;
   assign bus.cmp_flag   = flg_q.cmp;
   assign bus.shift_flag = flg_q.shift;
   assign bus.zero_flag  = flg_q.zero;
   assign bus.div0_flag  = flg_q.div0;
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the team's 16-bit single-cycle ALU. It keeps the same 4-bit ALU_FUN opcode map and flag set, and adds:
- a WIDTH parameter;
- a valid/ready input and output handshake;
- a sequential shift-add multiplier and restoring divider with a full-width upper result;
- variable shift and rotate;
- zero and divide-by-zero flags.

It sits between the operand register file and the writeback stage, and processes one operation at a time.

## Interface
Parameters:
- WIDTH, 16: operand and result width. Power of two, at least 4.
- SW, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- CLK  input  1  clock. All state updates on the rising edge.
- RST  input  1  reset. Asynchronous, active-low.
- IN_VALID  input  1  operation request.
- IN_READY  output  1  core can accept an operation. High only in IDLE.
- A  input  WIDTH  operand A. Sampled on accept.
- B  input  WIDTH  operand B. Sampled on accept.
- ALU_FUN  input  4  opcode. Sampled on accept.
- OUT_VALID  output  1  result and flags valid.
- OUT_READY  input  1  consumer takes the result.
- ALU_OUT  output  WIDTH  primary result.
- ALU_HI  output  WIDTH  product upper half, or division remainder. Otherwise 0.
- Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  output  1 each  class flags.
- Zero_Flag  output  1  ALU_OUT == 0.
- Div0_Flag  output  1  divide with B == 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: an accept occurs when IN_VALID && IN_READY. A, B and ALU_FUN are captured into internal registers.
  - From IDLE, single-cycle opcodes and divide-by-zero go to DONE. Multiply and divide with B != 0 go to BUSY with the iteration counter = 0.
  - BUSY: exactly WIDTH iterations, one per cycle. On the last iteration go to DONE.
  - DONE: OUT_VALID = 1. Outputs hold stable until OUT_READY = 1, then go to IDLE.
- Inputs that change after accept have no effect.
- Opcodes (unsigned arithmetic, results mod 2^WIDTH unless stated):
  - 0000 add: ALU_OUT = A+B; Carry_Flag = carry out of bit WIDTH-1; Arith_Flag = 1.
  - 0001 subtract: ALU_OUT = A-B; Carry_Flag = 1 when A < B (borrow); Arith_Flag = 1.
  - 0010 multiply: {ALU_HI, ALU_OUT} = full 2·WIDTH-bit product, computed shift-add. Arith_Flag = 1. Carry_Flag = 1 when ALU_HI != 0.
  - 0011 divide: ALU_OUT = quotient, ALU_HI = remainder, restoring, one quotient bit per cycle. Arith_Flag = 1. With B == 0: ALU_OUT = all ones, ALU_HI = A, Div0_Flag = 1, no BUSY phase.
  - Logic opcodes, each with Logic_Flag = 1: 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR.
  - Compare opcodes, each with CMP_Flag = 1; result otherwise 0:
    - 1010: ALU_OUT = 1 if A == B.
    - 1011: ALU_OUT = 2 if A > B.
    - 1100: ALU_OUT = 3 if A < B.
  - Shift opcodes, each with Shift_Flag = 1; shift amount = B[SW-1:0]:
    - 1101: logical right shift of A.
    - 1110: left shift of A.
    - 1111: rotate-left of A.
  - An amount of 0 passes A unchanged.
- Flag scope:
  - Flags not named for an opcode are 0.
  - ALU_HI = 0 except for multiply and divide.
  - Zero_Flag is valid for every opcode.

## Timing
- Reset (RST low, asynchronous):
  - FSM goes to IDLE and the iteration counter clears.
  - IN_READY = 1 once RST is released.
  - OUT_VALID = 0, ALU_OUT = 0, ALU_HI = 0, all flags = 0.
  - Reset during BUSY or DONE aborts the operation; no result is produced.
- Latency, measured from the accept edge to the first edge with OUT_VALID = 1:
  - Single-cycle opcodes and divide-by-zero: 1 cycle.
  - Multiply and divide: WIDTH+1 cycles.
- Throughput: accepts cannot overlap.
  - IN_READY is 0 in BUSY and DONE. It returns high the cycle after the OUT_READY handshake.
  - Minimum issue interval is 2 cycles for single-cycle ops and WIDTH+2 for multiply/divide.
- OUT_READY already high when DONE is entered: result transfers on that first DONE cycle.
- OUT_READY held low: DONE persists indefinitely. ALU_OUT, ALU_HI and flags are bit-stable.
- IN_VALID high while IN_READY is low is ignored. The requester must hold the request until accepted.
- Registered outputs change only on the edge entering DONE, or on reset.

## Test plan
- Reset mid-BUSY: issue divide 0xFFFF/0x0003, assert RST on iteration 5 → same edge OUT_VALID = 0, ALU_OUT = 0; after release IN_READY = 1 and no stale result appears.
- Add/subtract at WIDTH=16:
  - 0xFFFF+0x0001 → ALU_OUT 0x0000, Carry 1, Zero 1, Arith 1, 1-cycle latency.
  - 0x0003-0x0005 → 0xFFFE, Carry 1.
- Multiply 0xFFFF×0xFFFF → ALU_HI 0xFFFE, ALU_OUT 0x0001, Carry 1, OUT_VALID exactly 17 cycles after accept; operands changed during BUSY do not alter the result.
- Divide:
  - 1000/7 → ALU_OUT 142, ALU_HI 6, 17-cycle latency.
  - 0x1234/0 → ALU_OUT 0xFFFF, ALU_HI 0x1234, Div0 1, 1-cycle latency.
- Backpressure: OUT_READY low for 10 cycles after AND 0xF0F0&0x0FF0 → ALU_OUT 0x00F0, Logic 1, outputs stable, IN_READY 0 throughout; a held IN_VALID is accepted only after the handshake.
- Shifts and compares:
  - Rotate 0x8001 by 4 → 0x0018.
  - Right shift 0x8000 by 15 → 0x0001.
  - Compare 5 > 3 with 1011 → ALU_OUT 2, CMP 1.
  - Repeat the compare at WIDTH=8 and WIDTH=32.
